// File: rtl/hgcal_input_packer.sv
// Serial-to-parallel feeder for the HGCAL autoencoder layer 0: quantises raw
// samples, assembles N_FEAT features per frame and hands frames out over valid/ready.
module hgcal_input_packer #(
    parameter int N_FEAT = 48,
    parameter int IN_W   = 8,
    parameter int Q_W    = 2,
    parameter int SHIFT  = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [IN_W-1:0]         s_data,
    input  logic                    s_last,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [N_FEAT*Q_W-1:0]   m_data,
    output logic                    m_err
);

    localparam int IDX_W   = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
    localparam int FRAME_W = N_FEAT * Q_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FEAT - 1);
    localparam logic [IN_W:0]    ROUND    = (IN_W + 1)'(1) << (SHIFT - 1);
    localparam logic [IN_W:0]    QMAX_W   = (IN_W + 1)'((1 << Q_W) - 1);

    typedef enum logic [1:0] {FILL, HOLD, RESYNC} state_t;

    state_t               state_reg, state_next;
    logic [IDX_W-1:0]     idx_reg, idx_next;
    logic                 s_ready_reg;
    logic                 m_valid_reg;
    logic [FRAME_W-1:0]   m_data_reg;
    logic                 m_err_reg, err_next;
    logic                 slot_we, load_direct, load_hold;
    logic                 accept, can_load, at_last;

    logic [Q_W-1:0]       asm_reg [N_FEAT];
    logic [FRAME_W-1:0]   asm_flat;
    logic [FRAME_W-1:0]   direct_flat;

    logic [IN_W:0]        sum;
    logic [IN_W:0]        shifted;
    logic [Q_W-1:0]       q;

    // Round to nearest by adding half an LSB before the shift, then clip.
    assign sum     = {1'b0, s_data} + ROUND;
    assign shifted = sum >> SHIFT;
    assign q       = (shifted > QMAX_W) ? QMAX_W[Q_W-1:0] : shifted[Q_W-1:0];

    assign accept   = s_valid & s_ready_reg;
    assign can_load = ~m_valid_reg | m_ready;
    assign at_last  = (idx_reg == LAST_IDX);

    assign s_ready = s_ready_reg;
    assign m_valid = m_valid_reg;
    assign m_data  = m_data_reg;
    assign m_err   = m_err_reg;

    always_comb begin
        state_next  = state_reg;
        idx_next    = idx_reg;
        err_next    = 1'b0;
        slot_we     = 1'b0;
        load_direct = 1'b0;
        load_hold   = 1'b0;
        case (state_reg)
            FILL: begin
                if (accept) begin
                    if (!at_last) begin
                        if (s_last) begin
                            err_next = 1'b1;
                            idx_next = '0;
                        end else begin
                            slot_we  = 1'b1;
                            idx_next = idx_reg + IDX_W'(1);
                        end
                    end else if (s_last) begin
                        slot_we  = 1'b1;
                        idx_next = '0;
                        if (can_load) begin
                            load_direct = 1'b1;
                        end else begin
                            state_next = HOLD;
                        end
                    end else begin
                        err_next   = 1'b1;
                        idx_next   = '0;
                        state_next = RESYNC;
                    end
                end
            end
            HOLD: begin
                if (can_load) begin
                    load_hold  = 1'b1;
                    idx_next   = '0;
                    state_next = FILL;
                end
            end
            RESYNC: begin
                if (accept && s_last) begin
                    idx_next   = '0;
                    state_next = FILL;
                end
            end
            default: begin
                idx_next   = '0;
                state_next = FILL;
            end
        endcase
    end

    // The direct path bypasses the last slot so a completed frame can leave on the
    // same edge its final sample arrives.
    generate
        for (genvar gi = 0; gi < N_FEAT; gi++) begin : g_slot
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    asm_reg[gi] <= '0;
                end else if (slot_we && (idx_reg == IDX_W'(gi))) begin
                    asm_reg[gi] <= q;
                end
            end
            assign asm_flat[gi*Q_W +: Q_W]    = asm_reg[gi];
            assign direct_flat[gi*Q_W +: Q_W] = (gi == N_FEAT - 1) ? q : asm_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= FILL;
            idx_reg     <= '0;
            s_ready_reg <= 1'b0;
            m_valid_reg <= 1'b0;
            m_data_reg  <= '0;
            m_err_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            idx_reg     <= idx_next;
            s_ready_reg <= (state_next != HOLD);
            m_err_reg   <= err_next;
            if (load_direct) begin
                m_data_reg  <= direct_flat;
                m_valid_reg <= 1'b1;
            end else if (load_hold) begin
                m_data_reg  <= asm_flat;
                m_valid_reg <= 1'b1;
            end else if (m_ready) begin
                m_valid_reg <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hgcal_input_packer.sv
// Scoreboard bench for hgcal_input_packer: stimulus pushes expected frames, a
// negedge monitor pops and compares every consumed frame.
module tb_hgcal_input_packer;

    localparam int N_FEAT = 48;
    localparam int FW     = 96;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [7:0]    s_data = 8'd0;
    logic          s_last = 1'b0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [FW-1:0] m_data;
    logic          m_err;

    always #5 clk = ~clk;

    hgcal_input_packer #(.N_FEAT(48), .IN_W(8), .Q_W(2), .SHIFT(3)) dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_last  (s_last),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_err   (m_err)
    );

    int            checks = 0;
    int            errors = 0;
    logic [FW-1:0] exp_q[$];
    int            consume_cyc[$];
    int            err_seen = 0;
    int            cyc = 0;
    bit            b2b_active = 1'b0;
    int            sready_drops = 0;
    logic          hold_prev = 1'b0;
    logic [FW-1:0] data_prev = '0;

    // Hand-derived thresholds for the default quantiser
    function automatic logic [1:0] q_ref(input logic [7:0] d);
        if (d < 8'd4)  return 2'd0;
        if (d < 8'd12) return 2'd1;
        if (d < 8'd20) return 2'd2;
        return 2'd3;
    endfunction

    function automatic logic [7:0] gen(input int f, input int i);
        return 8'((f * 37 + i * 13 + f * i) & 255);
    endfunction

    task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            if (m_err) err_seen++;
            if (b2b_active && !s_ready) sready_drops++;
            if (hold_prev) begin
                chk("hold_valid", FW'(m_valid), FW'(1));
                chk("hold_data", m_data, data_prev);
            end
            if (m_valid && m_ready) begin
                consume_cyc.push_back(cyc);
                $display("frame consumed cycle %0d data=%h", cyc, m_data);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame: got %h expected none", m_data);
                end else begin
                    chk("frame", m_data, exp_q.pop_front());
                end
            end
            hold_prev = m_valid && !m_ready;
            data_prev = m_data;
        end else begin
            hold_prev = 1'b0;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the sample is accepted.
    task automatic send(input logic [7:0] d, input logic l);
        int t;
        t = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        while (!s_ready && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        if (!s_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: s_ready=%0b required 1", s_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_frame(input int f, output logic [FW-1:0] e);
        e = '0;
        for (int i = 0; i < N_FEAT; i++) e[i*2 +: 2] = q_ref(gen(f, i));
        exp_q.push_back(e);
        for (int i = 0; i < N_FEAT; i++) send(gen(f, i), i == N_FEAT - 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [FW-1:0] e, e2, e3;
        logic [7:0]    sweep_vals [8];
        logic [1:0]    sweep_q    [8];
        sweep_vals = '{8'd0, 8'd3, 8'd4, 8'd11, 8'd12, 8'd19, 8'd20, 8'd255};
        sweep_q    = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};

        // Power-on reset
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_valid", FW'(m_valid), FW'(0));
        chk("rst_m_err", FW'(m_err), FW'(0));
        chk("rst_m_data", m_data, FW'(0));
        chk("rst_s_ready", FW'(s_ready), FW'(0));
        rst = 1'b1;
        chk("release_sready_before_clk", FW'(s_ready), FW'(0));
        @(posedge clk); #1;
        chk("release_sready", FW'(s_ready), FW'(1));
        m_ready = 1'b1;

        // Quantisation sweep
        e = '0;
        for (int i = 0; i < N_FEAT; i++) e[i*2 +: 2] = sweep_q[i % 8];
        exp_q.push_back(e);
        for (int i = 0; i < N_FEAT; i++) send(sweep_vals[i % 8], i == N_FEAT - 1);
        chk("sweep_latency_m_valid", FW'(m_valid), FW'(1));
        idle();
        repeat (3) @(posedge clk);
        #1;

        // Reset in the middle of a frame
        for (int i = 0; i < 20; i++) send(gen(9, i), 1'b0);
        rst = 1'b0;
        #1;
        chk("midrst_m_valid", FW'(m_valid), FW'(0));
        chk("midrst_m_err", FW'(m_err), FW'(0));
        chk("midrst_m_data", m_data, FW'(0));
        chk("midrst_s_ready", FW'(s_ready), FW'(0));
        idle();
        @(posedge clk); #1;
        chk("midrst_s_ready_hold", FW'(s_ready), FW'(0));
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_release_sready", FW'(s_ready), FW'(1));
        send_frame(1, e);
        idle();
        repeat (3) @(posedge clk);
        #1;

        // Backpressure: second frame parks in HOLD
        m_ready = 1'b0;
        send_frame(2, e2);
        send_frame(3, e3);
        idle();
        chk("bp_hold_sready", FW'(s_ready), FW'(0));
        repeat (3) @(posedge clk);
        #1;
        chk("bp_hold_sready_stays", FW'(s_ready), FW'(0));
        chk("bp_frame1_stable", m_data, e2);
        m_ready = 1'b1;
        @(posedge clk); #1;
        m_ready = 1'b0;
        chk("bp_release_m_valid", FW'(m_valid), FW'(1));
        chk("bp_release_sready", FW'(s_ready), FW'(1));
        chk("bp_release_data", m_data, e3);
        repeat (2) @(posedge clk);
        #1;
        m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Early last on sample 10
        for (int i = 0; i <= 10; i++) send(gen(4, i), i == 10);
        send_frame(5, e);
        idle();
        repeat (3) @(posedge clk);
        #1;

        // Missing last, then RESYNC discards a 5-sample tail
        for (int i = 0; i < N_FEAT; i++) send(gen(6, i), 1'b0);
        for (int i = 0; i < 5; i++) send(gen(7, i), i == 4);
        send_frame(8, e);
        idle();
        repeat (3) @(posedge clk);
        #1;
        chk("m_err_pulses", FW'(err_seen), FW'(2));

        // Back-to-back streaming
        consume_cyc.delete();
        b2b_active = 1'b1;
        for (int f = 10; f < 20; f++) send_frame(f, e);
        b2b_active = 1'b0;
        idle();
        repeat (4) @(posedge clk);
        #1;
        chk("b2b_frame_count", FW'(consume_cyc.size()), FW'(10));
        for (int k = 1; k < consume_cyc.size(); k++)
            chk("b2b_spacing", FW'(consume_cyc[k] - consume_cyc[k-1]), FW'(48));
        chk("b2b_sready_drops", FW'(sready_drops), FW'(0));

        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_empty", FW'(exp_q.size()), FW'(0));
        chk("m_err_total", FW'(err_seen), FW'(2));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
